// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver. Collects WIDTH accepted bits into a word in
// MSB-first or LSB-first order, holds the completed word for a valid/read
// handshake and reports dropped words (overrun) and early frame syncs (frame_err).
module serial_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  input  logic             msb_first,
  input  logic             data_rd,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_reg;
  logic [CW-1:0]    count_reg;
  logic             order_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             data_valid_reg;
  logic             overrun_reg;
  logic             frame_err_reg;

  logic             accept;
  logic             first_bit;
  logic             order_next;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    pos;
  logic [CW-1:0]    count_next;
  logic             last_bit;
  logic             frame_err_next;

  // Decode the bit being accepted this cycle: its word position, order and the assembled word.
  always_comb begin
    accept         = en & sin_valid;
    // A start (or an idle counter) makes this bit the first of a new word.
    first_bit      = accept & (start | (count_reg == '0));
    order_next     = first_bit ? msb_first : order_reg;
    // Shift into a cleared register on bit 0 so a discarded partial word never leaks in.
    base           = first_bit ? '0 : sr_reg;
    sr_next        = order_next ? {base[WIDTH-2:0], sin} : {sin, base[WIDTH-1:1]};
    pos            = start ? '0 : count_reg;
    last_bit       = accept & (pos == LAST_POS);
    count_next     = last_bit ? '0 : pos + 1'b1;
    frame_err_next = accept & start & (count_reg != '0);
  end

  // Capture state, word hand-off, read handshake and error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_reg         <= '0;
      count_reg      <= '0;
      order_reg      <= 1'b0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      frame_err_reg <= frame_err_next;
      if (accept) begin
        sr_reg    <= sr_next;
        order_reg <= order_next;
        count_reg <= count_next;
      end
      if (last_bit) begin
        // A read on the completion edge frees the holding register for the new word.
        if (!data_valid_reg || data_rd) begin
          data_out_reg   <= sr_next;
          data_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (data_rd && data_valid_reg) begin
        data_valid_reg <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign busy       = (count_reg != '0);
  assign overrun    = overrun_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_serial_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         start = 1'b0;
  logic         msb_first = 1'b0;
  logic         data_rd = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic         bits_q[$];
  logic         m_order = 1'b0;
  logic [W-1:0] m_dout = '0;
  logic         m_dv = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_ferr = 1'b0;

  serial_deserializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .start      (start),
    .msb_first  (msb_first),
    .data_rd    (data_rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    logic         rd_clear;
    logic         ferr_n;
    logic [W-1:0] word;
    if (!reset) begin
      bits_q.delete();
      m_order = 1'b0;
      m_dout  = '0;
      m_dv    = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
      return;
    end
    ferr_n   = 1'b0;
    rd_clear = data_rd && m_dv;
    if (en && sin_valid) begin
      if (start) begin
        if (bits_q.size() != 0) ferr_n = 1'b1;
        bits_q.delete();
      end
      if (bits_q.size() == 0) m_order = msb_first;
      bits_q.push_back(sin);
      if (bits_q.size() == W) begin
        word = '0;
        for (int i = 0; i < W; i++) begin
          if (m_order) word[W-1-i] = bits_q[i];
          else         word[i]     = bits_q[i];
        end
        bits_q.delete();
        if (!m_dv || data_rd) begin
          m_dout   = word;
          m_dv     = 1'b1;
          rd_clear = 1'b0;
          $display("word %b delivered (msb_first=%0d) at %0t", word, m_order, $time);
        end else begin
          m_ovr = 1'b1;
          $display("word %b dropped, overrun at %0t", word, $time);
        end
      end
    end
    if (rd_clear) m_dv = 1'b0;
    m_ferr = ferr_n;
  endtask

  // Apply one cycle of inputs, step the model, and compare all outputs at the falling edge.
  task automatic cyc(input logic r, input logic e, input logic s, input logic sv,
                     input logic st, input logic msb, input logic rd);
    reset = r; en = e; sin = s; sin_valid = sv; start = st; msb_first = msb; data_rd = rd;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("data_out",   32'(data_out),   32'(m_dout));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("busy",       32'(busy),       32'(bits_q.size() != 0));
    check("overrun",    32'(overrun),    32'(m_ovr));
    check("frame_err",  32'(frame_err),  32'(m_ferr));
  endtask

  task automatic bit_in(input logic s, input logic st, input logic msb, input logic rd);
    cyc(1'b1, 1'b1, s, 1'b1, st, msb, rd);
  endtask

  task automatic idle(input logic rd);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    do_reset();
    check("rst_dout", 32'(data_out), 32'h0);
    check("rst_dv",   32'(data_valid), 32'h0);

    // MSB-first 1011, then read
    bit_in(1, 1, 1, 0); bit_in(0, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(1, 0, 1, 0);
    check("t1_dout", 32'(data_out), 32'hB);
    check("t1_dv",   32'(data_valid), 32'h1);
    check("t1_busy", 32'(busy), 32'h0);
    idle(1);
    check("t1_rd", 32'(data_valid), 32'h0);

    // LSB-first 1,0,1,1 with msb_first toggled mid-word
    bit_in(1, 0, 0, 0); bit_in(0, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(1, 0, 1, 0);
    check("t2_dout", 32'(data_out), 32'hD);
    idle(1);

    // Two words without reads -> overrun, then reset clears it
    bit_in(1, 1, 1, 0); bit_in(0, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(1, 0, 1, 0);
    bit_in(0, 1, 1, 0); bit_in(1, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(0, 0, 1, 0);
    check("t3_dout", 32'(data_out), 32'hB);
    check("t3_ovr",  32'(overrun), 32'h1);
    idle(0); idle(1);
    check("t3_sticky", 32'(overrun), 32'h1);
    do_reset();
    check("t3_rst_ovr",  32'(overrun), 32'h0);
    check("t3_rst_dout", 32'(data_out), 32'h0);

    // Read on the completion edge of a second word
    bit_in(1, 1, 1, 0); bit_in(0, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(1, 0, 1, 0);
    bit_in(0, 1, 1, 0); bit_in(1, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(0, 0, 1, 1);
    check("t4_dout", 32'(data_out), 32'h6);
    check("t4_dv",   32'(data_valid), 32'h1);
    check("t4_ovr",  32'(overrun), 32'h0);
    idle(1);

    // Frame error: 1,1 then start with 0,0,1,0
    bit_in(1, 1, 1, 0); bit_in(1, 0, 1, 0);
    bit_in(0, 1, 1, 0);
    check("t5_ferr", 32'(frame_err), 32'h1);
    bit_in(0, 0, 1, 0);
    check("t5_ferr_pulse", 32'(frame_err), 32'h0);
    bit_in(1, 0, 1, 0); bit_in(0, 0, 1, 0);
    check("t5_dout", 32'(data_out), 32'h2);
    idle(1);

    // Enable hold mid-word
    bit_in(1, 1, 1, 0); bit_in(0, 0, 1, 0);
    cyc(1, 0, 1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 1, 0, 0); cyc(1, 0, 1, 1, 1, 0, 0);
    check("t6_busy_hold", 32'(busy), 32'h1);
    bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
    check("t6_dout", 32'(data_out), 32'h9);
    idle(1);

    // Reset mid-word discards partial bits
    bit_in(1, 1, 1, 0); bit_in(1, 0, 1, 0);
    do_reset();
    check("t7_busy", 32'(busy), 32'h0);
    bit_in(0, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(0, 0, 1, 0); bit_in(1, 0, 1, 0);
    check("t7_dout", 32'(data_out), 32'h5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 59) != 0),
          ($urandom_range(0, 9) < 8),
          1'($urandom),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 19) < 3),
          1'($urandom),
          ($urandom_range(0, 9) < 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
